// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for parameterized_alu:
//   - 4-bit opcode encodings for ALU_Func
//   - class_flags_t : packed bundle of the four operation-class flags
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // One bit per operation class; at most one is set for any opcode.
  typedef struct packed {
    logic arith;
    logic logic_op;
    logic cmp;
    logic shift;
  } class_flags_t;

endpackage

// File: rtl/alu_class_decode.sv
// ---------------------------------------------------------------------------
// alu_class_decode
// Purely combinational decode of the ALU opcode into its operation class.
// Ports:
//   alu_func : in  [3:0]          opcode
//   flags    : out class_flags_t  {arith, logic_op, cmp, shift}
// The unused opcode (OP_NOP) produces all-zero flags.
// ---------------------------------------------------------------------------
module alu_class_decode
  import alu_pkg::*;
(
  input  logic [3:0]   alu_func,
  output class_flags_t flags
);

  // Map each opcode to exactly one class flag.
  always_comb begin
    flags = '{arith: 1'b0, logic_op: 1'b0, cmp: 1'b0, shift: 1'b0};
    case (alu_func)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV:                   flags.arith    = 1'b1;
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:  flags.logic_op = 1'b1;
      OP_EQ, OP_GT, OP_LT:                              flags.cmp      = 1'b1;
      OP_SHR, OP_SHL:                                   flags.shift    = 1'b1;
      default:                                          flags.arith    = 1'b0;
    endcase
  end

endmodule

// File: rtl/parameterized_alu.sv
// ---------------------------------------------------------------------------
// parameterized_alu
// N-bit unsigned ALU with a single registered output stage.
// Ports:
//   clk      : in   clock, all state on rising edge
//   rst      : in   synchronous active-high reset
//   ALU_Func : in   [3:0] opcode (see alu_pkg)
//   A, B     : in   [N-1:0] unsigned operands
//   ALU_out  : out  [N-1:0] registered result
//   Carry    : out  registered carry (ADD) / borrow (SUB), 0 otherwise
//   Arith, Logic, CMP, Shift : out  registered operation-class flags
// Results appear one cycle after the inputs are sampled.
// ---------------------------------------------------------------------------
module parameterized_alu
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   ALU_Func,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] ALU_out,
  output logic         Carry,
  output logic         Arith,
  output logic         Logic,
  output logic         CMP,
  output logic         Shift
);

  localparam logic [N-1:0] ZERO_N = {N{1'b0}};
  localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ONES_N = {N{1'b1}};

  logic [N-1:0] result_s;
  logic         carry_s;
  logic [N:0]   sum_s;
  class_flags_t flags_s;

  // Extended-width sum so the ADD carry is simply its top bit.
  assign sum_s = {1'b0, A} + {1'b0, B};

  alu_class_decode u_class_decode (
    .alu_func (ALU_Func),
    .flags    (flags_s)
  );

  // Datapath: one case per opcode producing next result and carry.
  always_comb begin
    result_s = ZERO_N;
    carry_s  = 1'b0;
    case (ALU_Func)
      OP_ADD: begin
        result_s = sum_s[N-1:0];
        carry_s  = sum_s[N];
      end
      OP_SUB: begin
        result_s = A - B;
        carry_s  = (A < B);
      end
      OP_MUL:  result_s = A * B;
      OP_DIV: begin
        // Divide-by-zero saturates instead of relying on tool-defined behaviour.
        if (B == ZERO_N) begin
          result_s = ONES_N;
        end else begin
          result_s = A / B;
        end
      end
      OP_AND:  result_s = A & B;
      OP_OR:   result_s = A | B;
      OP_NAND: result_s = ~(A & B);
      OP_NOR:  result_s = ~(A | B);
      OP_XOR:  result_s = A ^ B;
      OP_XNOR: result_s = ~(A ^ B);
      OP_EQ:   result_s = (A == B) ? ONE_N : ZERO_N;
      OP_GT:   result_s = (A >  B) ? ONE_N : ZERO_N;
      OP_LT:   result_s = (A <  B) ? ONE_N : ZERO_N;
      OP_SHR:  result_s = {1'b0, A[N-1:1]};
      OP_SHL:  result_s = {A[N-2:0], 1'b0};
      default: result_s = ZERO_N;
    endcase
  end

  // Output register stage; reset clears everything including any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_out <= ZERO_N;
      Carry   <= 1'b0;
      Arith   <= 1'b0;
      Logic   <= 1'b0;
      CMP     <= 1'b0;
      Shift   <= 1'b0;
    end else begin
      ALU_out <= result_s;
      Carry   <= carry_s;
      Arith   <= flags_s.arith;
      Logic   <= flags_s.logic_op;
      CMP     <= flags_s.cmp;
      Shift   <= flags_s.shift;
    end
  end

endmodule

// File: tb/tb_parameterized_alu.sv
// ---------------------------------------------------------------------------
// tb_parameterized_alu
// Scoreboard bench for parameterized_alu (N=16). The driver applies inputs
// on the falling edge and queues the expected registered response; the
// monitor pops and compares shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_parameterized_alu;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ALU_Func = 4'd0;
  logic [N-1:0] A = 16'd0;
  logic [N-1:0] B = 16'd0;
  logic [N-1:0] ALU_out;
  logic         Carry, Arith, Logic, CMP, Shift;

  typedef struct {
    logic [15:0] out;
    logic        carry;
    logic [3:0]  flags;   // {arith, logic, cmp, shift}
    logic [3:0]  op;
    logic        rst;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  parameterized_alu #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .ALU_Func (ALU_Func),
    .A        (A),
    .B        (B),
    .ALU_out  (ALU_out),
    .Carry    (Carry),
    .Arith    (Arith),
    .Logic    (Logic),
    .CMP      (CMP),
    .Shift    (Shift)
  );

  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic on 32-bit integers, masked to 16 bits.
  function automatic exp_t model(input logic r, input logic [3:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int unsigned ua, ub, s;
    ua = a;
    ub = b;
    e.out = 16'd0; e.carry = 1'b0; e.flags = 4'b0000; e.op = op; e.rst = r;
    if (r) return e;
    case (op)
      4'd0:  begin s = ua + ub; e.out = 16'(s); e.carry = (s > 32'd65535); end
      4'd1:  begin e.out = 16'(ua - ub); e.carry = (ua < ub); end
      4'd2:  e.out = 16'(ua * ub);
      4'd3:  e.out = (ub == 0) ? 16'hFFFF : 16'(ua / ub);
      4'd4:  e.out = 16'(ua & ub);
      4'd5:  e.out = 16'(ua | ub);
      4'd6:  e.out = 16'(~(ua & ub));
      4'd7:  e.out = 16'(~(ua | ub));
      4'd8:  e.out = 16'(ua ^ ub);
      4'd9:  e.out = 16'(~(ua ^ ub));
      4'd10: e.out = (ua == ub) ? 16'd1 : 16'd0;
      4'd11: e.out = (ua > ub)  ? 16'd1 : 16'd0;
      4'd12: e.out = (ua < ub)  ? 16'd1 : 16'd0;
      4'd13: e.out = 16'(ua / 2);
      4'd14: e.out = 16'(ua * 2);
      default: e.out = 16'd0;
    endcase
    if (op <= 4'd3)       e.flags = 4'b1000;
    else if (op <= 4'd9)  e.flags = 4'b0100;
    else if (op <= 4'd12) e.flags = 4'b0010;
    else if (op <= 4'd14) e.flags = 4'b0001;
    else                  e.flags = 4'b0000;
    return e;
  endfunction

  task automatic drive(input logic r, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    rst      = r;
    ALU_Func = op;
    A        = a;
    B        = b;
    q.push_back(model(r, op, a, b));
  endtask

  // Monitor: one queued expectation per rising edge while stimulus is active.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({ALU_out, Carry, Arith, Logic, CMP, Shift} !== {e.out, e.carry, e.flags}) begin
        errors++;
        $display("FAIL alu rst=%b op=%0d: got out=%h carry=%b flags=%b%b%b%b, expected out=%h carry=%b flags=%b",
                 e.rst, e.op, ALU_out, Carry, Arith, Logic, CMP, Shift, e.out, e.carry, e.flags);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;

    // Reset state
    drive(1'b1, 4'd0, 16'h1234, 16'h5678);
    drive(1'b1, 4'd2, 16'hFFFF, 16'hFFFF);

    // Directed cases
    drive(1'b0, 4'd0,  16'h0010, 16'h000A);
    drive(1'b0, 4'd0,  16'hFFFD, 16'h0003);
    drive(1'b0, 4'd1,  16'd16,   16'd10);
    drive(1'b0, 4'd1,  16'd10,   16'd16);
    drive(1'b0, 4'd2,  16'd16,   16'd10);
    drive(1'b0, 4'd3,  16'd200,  16'd10);
    drive(1'b0, 4'd3,  16'd200,  16'd0);
    for (int i = 4; i <= 9; i++) drive(1'b0, 4'(i), 16'h0011, 16'h1111);
    drive(1'b0, 4'd10, 16'd12886, 16'd12886);
    drive(1'b0, 4'd11, 16'd12889, 16'd12886);
    drive(1'b0, 4'd12, 16'd12883, 16'd12886);
    drive(1'b0, 4'd12, 16'd12889, 16'd12886);
    drive(1'b0, 4'd13, 16'd620,   16'hBEEF);
    drive(1'b0, 4'd14, 16'd620,   16'h1234);
    drive(1'b0, 4'd14, 16'h8001,  16'h0000);
    drive(1'b0, 4'd15, 16'hFFFF,  16'hFFFF);

    // Reset in the middle of a carrying ADD stream, then resume
    drive(1'b0, 4'd0, 16'hFFFF, 16'h0002);
    drive(1'b1, 4'd0, 16'hFFFF, 16'h0003);
    drive(1'b0, 4'd0, 16'hFFFF, 16'h0004);
    drive(1'b0, 4'd1, 16'h0000, 16'h0001);

    // Randomized stimulus with biased corner operands
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = a;
        2:       a = 16'hFFFF;
        default: ;
      endcase
      drive(($urandom_range(0, 19) == 0), op, a, b);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
